sad_search_sched: RTL and testbench

- Full-search motion-estimation scheduler that sequences the SAD datapath over every candidate displacement (dx, dy) in a ±RANGE window.
- For each candidate it streams BLK reference-row load requests, pulses a compute start and waits for the SAD result.
- Tracks the minimum SAD and its motion vector.
- Sits between the frame-memory/FIFO loader and the SAD_top datapath.

---
 rtl/sad_search_sched.sv | 119 +++++++++++
 tb/tb_sad_search_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sad_search_sched.sv
// sad_search_sched: full-search motion-estimation scheduler driving row loads and SAD compute per candidate.
// Optional SAD_EARLY_EXIT_EN: a zero SAD ends the search immediately.
module sad_search_sched #(
    parameter int BLK   = 16,
    parameter int RANGE = 7,
    parameter int SAD_W = 16,
    parameter int MV_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     ld_valid,
    input  logic                     ld_ready,
    output logic [$clog2(BLK)-1:0]   ld_row,
    output logic [MV_W-1:0]          ld_dx,
    output logic [MV_W-1:0]          ld_dy,
    output logic                     sad_start,
    input  logic                     sad_valid,
    input  logic [SAD_W-1:0]         sad_in,
    output logic [SAD_W-1:0]         best_sad,
    output logic [MV_W-1:0]          best_mvx,
    output logic [MV_W-1:0]          best_mvy,
    output logic [7:0]               cand_cnt
);
    localparam int RW = $clog2(BLK);
    localparam logic [MV_W-1:0] LO = MV_W'(-RANGE);
    localparam logic [MV_W-1:0] HI = MV_W'(RANGE);

    typedef enum logic [2:0] {IDLE, LOAD, CALC, WAIT, UPDATE, DONE} state_t;

    state_t             r_state, w_next;
    logic [RW-1:0]      r_row;
    logic [MV_W-1:0]    r_dx, r_dy, r_mvx, r_mvy;
    logic [SAD_W-1:0]   r_sad, r_best;
    logic [7:0]         r_cnt;
    logic               w_last_row, w_last_cand, w_better, w_finish;

    assign w_last_row  = r_row == RW'(BLK - 1);
    assign w_last_cand = r_dx == HI && r_dy == HI;
    // Strict compare keeps the earliest raster candidate on ties.
    assign w_better    = r_cnt == 8'd0 || r_sad < r_best;
`ifdef SAD_EARLY_EXIT_EN
    assign w_finish    = w_last_cand || r_sad == '0;
`else
    assign w_finish    = w_last_cand;
`endif

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? LOAD : IDLE;
            LOAD:    w_next = (ld_ready && w_last_row) ? CALC : LOAD;
            CALC:    w_next = WAIT;
            WAIT:    w_next = sad_valid ? UPDATE : WAIT;
            UPDATE:  w_next = w_finish ? DONE : LOAD;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = r_state != IDLE;
        done      = r_state == DONE;
        ld_valid  = r_state == LOAD;
        sad_start = r_state == CALC;
        ld_row    = r_row;
        ld_dx     = r_dx;
        ld_dy     = r_dy;
        best_sad  = r_best;
        best_mvx  = r_mvx;
        best_mvy  = r_mvy;
        cand_cnt  = r_cnt;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_row  <= '0;
            r_dx   <= '0;
            r_dy   <= '0;
            r_mvx  <= '0;
            r_mvy  <= '0;
            r_sad  <= '0;
            r_best <= '1;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_dx   <= LO;
                    r_dy   <= LO;
                    r_row  <= '0;
                    r_cnt  <= '0;
                    r_best <= '1;
                    r_mvx  <= '0;
                    r_mvy  <= '0;
                end
                LOAD: if (ld_ready) r_row <= w_last_row ? '0 : r_row + 1'b1;
                WAIT: if (sad_valid) r_sad <= sad_in;
                UPDATE: begin
                    if (w_better) begin
                        r_best <= r_sad;
                        r_mvx  <= r_dx;
                        r_mvy  <= r_dy;
                    end
                    r_cnt <= r_cnt + 8'd1;
                    if (!w_last_cand) begin
                        r_dx <= (r_dx == HI) ? LO : r_dx + 1'b1;
                        r_dy <= (r_dx == HI) ? r_dy + 1'b1 : r_dy;
                    end
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_sad_search_sched.sv
// tb_sad_search_sched: vector table of search scenarios plus candidate-order scoreboard and SAD responder.
module tb_sad_search_sched;
    logic        clk = 0, rst = 1, start = 0, ld_ready = 1, sad_valid = 0;
    logic [15:0] sad_in = 0;
    logic        busy, done, ld_valid, sad_start;
    logic [3:0]  ld_row, ld_dx, ld_dy, best_mvx, best_mvy;
    logic [15:0] best_sad;
    logic [7:0]  cand_cnt;

    sad_search_sched dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_row(ld_row),
        .ld_dx(ld_dx), .ld_dy(ld_dy), .sad_start(sad_start),
        .sad_valid(sad_valid), .sad_in(sad_in), .best_sad(best_sad),
        .best_mvx(best_mvx), .best_mvy(best_mvy), .cand_cnt(cand_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {int dx; int dy;} cand_t;
    typedef struct {int mode; bit tog; int mvx; int mvy; int sad; int cnt; int cyc;} vec_t;

    cand_t sb[$];
    vec_t  vecs[$];
    int checks = 0, failures = 0;
    int mode = 0, cyc = 0, first_lv = -1, done_cyc = -1, done_cnt = 0;
    int acc = 0, exp_row = 0, cd = 0, cdx = 0, cdy = 0;
    bit toggle = 0;

    function automatic int iabs(int x);
        return x < 0 ? -x : x;
    endfunction

    function automatic int model(int m, int dx, int dy);
        case (m)
            0: return 10*iabs(dx-2) + 10*iabs(dy+3) + 5;
            1: return 100;
            2: return 1000 - 3*((dy+7)*15 + dx + 7);
            3: return 65535;
            4: return (dx == 0 && dy == 0) ? 0 : 10*iabs(dx-2) + 10*iabs(dy+3) + 5;
            default: return 0;
        endcase
    endfunction

    task automatic chk(string n, int a, int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", n, a, e);
        end
    endtask

    task automatic fill_sb();
        sb.delete();
        for (int y = -7; y <= 7; y++)
            for (int x = -7; x <= 7; x++) sb.push_back('{x, y});
        exp_row = 0; acc = 0; first_lv = -1; done_cnt = 0; done_cyc = -1;
    endtask

    // Load-side stall driver, row/candidate monitor and SAD responder with k=3.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst) begin
            cd = 0;
            sad_valid = 0;
        end else begin
            ld_ready = toggle ? !ld_ready : 1'b1;
            if (ld_valid && first_lv < 0) first_lv = cyc;
            if (ld_valid && ld_ready) begin
                chk("ld_row", int'(ld_row), exp_row);
                exp_row = (exp_row + 1) % 16;
                acc++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            sad_valid = 0;
            if (sad_start) begin
                chk("row_accepts", acc, 16);
                acc = 0;
                cdx = int'($signed(ld_dx));
                cdy = int'($signed(ld_dy));
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_empty actual=extra_candidate(%0d,%0d) expected=none", cdx, cdy);
                end else begin
                    cand_t c;
                    c = sb.pop_front();
                    chk("cand_dx", cdx, c.dx);
                    chk("cand_dy", cdy, c.dy);
                    cdx = c.dx;
                    cdy = c.dy;
                end
                cd = 3;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    sad_valid = 1;
                    sad_in = 16'(model(mode, cdx, cdy));
                end
            end
        end
    end

    task automatic run_search(vec_t v);
        mode = v.mode;
        toggle = v.tog;
        fill_sb();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        chk("busy_after_start", int'(busy), 1);
        for (int i = 0; i < 30000 && !done; i++) @(negedge clk);
        if (!done) begin
            checks++; failures++;
            $display("FAIL search_timeout actual=no_done expected=done mode=%0d", v.mode);
        end else begin
            start = 1;
            @(negedge clk) start = 0;
            chk("done_one_cycle", int'(done), 0);
            chk("busy_after_done", int'(busy), 0);
            chk("done_count", done_cnt, 1);
            chk("best_sad", int'(best_sad), v.sad);
            chk("best_mvx", int'($signed(best_mvx)), v.mvx);
            chk("best_mvy", int'($signed(best_mvy)), v.mvy);
            chk("cand_cnt", int'(cand_cnt), v.cnt);
            chk("sb_left", sb.size(), 225 - v.cnt);
            if (v.cyc >= 0) chk("search_cycles", done_cyc - first_lv, v.cyc);
            repeat (3) @(negedge clk);
            chk("start_in_done_ignored", int'(busy), 0);
            chk("best_hold", int'(best_sad), v.sad);
        end
    endtask

    initial begin
        bit lv;
        vecs.push_back('{0, 1'b0, 2, -3, 5, 225, 4725});
        vecs.push_back('{1, 1'b0, -7, -7, 100, 225, 4725});
        vecs.push_back('{2, 1'b0, 7, 7, 328, 225, 4725});
        vecs.push_back('{3, 1'b0, -7, -7, 65535, 225, 4725});
        vecs.push_back('{0, 1'b1, 2, -3, 5, 225, -1});
`ifdef SAD_EARLY_EXIT_EN
        vecs.push_back('{4, 1'b0, 0, 0, 0, 113, 2373});
`endif
        #2 rst = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        lv = 0;
        repeat (100) begin
            @(negedge clk);
            if (ld_valid) lv = 1;
        end
        chk("idle_ld_valid", int'(lv), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sad_start", int'(sad_start), 0);
        chk("rst_ld_row", int'(ld_row), 0);
        chk("rst_ld_dx", int'(ld_dx), 0);
        chk("rst_ld_dy", int'(ld_dy), 0);
        chk("rst_best_sad", int'(best_sad), 65535);
        chk("rst_best_mvx", int'(best_mvx), 0);
        chk("rst_best_mvy", int'(best_mvy), 0);
        chk("rst_cand_cnt", int'(cand_cnt), 0);

        mode = 0;
        toggle = 0;
        fill_sb();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        for (int i = 0; i < 5000 && cand_cnt != 8'd20; i++) @(negedge clk);
        start = 1;
        @(negedge clk) start = 0;
        for (int i = 0; i < 5000 && cand_cnt != 8'd50; i++) @(negedge clk);
        chk("mid_cand_reached", int'(cand_cnt), 50);
        rst = 0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_cand_cnt", int'(cand_cnt), 0);
        chk("midrst_best_sad", int'(best_sad), 65535);
        chk("midrst_ld_valid", int'(ld_valid), 0);
        done_cnt = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        sb.delete();
        exp_row = 0;
        acc = 0;
        repeat (300) @(negedge clk);
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_idle", int'(busy), 0);

        foreach (vecs[i]) run_search(vecs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
